// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: load funct3 codes and writeback-source encodings.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2,
    WB_SEL_IMM = 2'd3
  } wb_sel_e;

  // Halfword loads need an even offset, word loads a zero offset.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if ((funct3 == F3_LH) || (funct3 == F3_LHU)) mis = addr_lo[0];
    else if (funct3 == F3_LW)                    mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB stage bundle: MEM-side controls/data in, register-file/forwarding/retire out.
interface wb_stage_if #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
);
  logic                 i_valid;
  logic                 i_stall;
  logic                 i_flush;
  logic [31:0]          i_inst;
  logic [4:0]           i_rd_addr;
  logic                 i_reg_wr_en;
  logic [1:0]           i_wb_sel;
  logic [2:0]           i_funct3;
  logic [1:0]           i_addr_lo;
  logic [XLEN-1:0]      i_dmem_rdata;
  logic [XLEN-1:0]      i_alu_result;
  logic [XLEN-1:0]      i_pc_plus4;
  logic [XLEN-1:0]      i_imm;

  logic                 o_rd_wen;
  logic [4:0]           o_rd_addr;
  logic [XLEN-1:0]      o_rd_wdata;
  logic                 o_fwd_valid;
  logic                 o_retire;
  logic [31:0]          o_retire_inst;
  logic                 o_trap_misaligned;
  logic [INSTRET_W-1:0] o_instret;

  modport master (
    output i_valid, i_stall, i_flush, i_inst, i_rd_addr, i_reg_wr_en, i_wb_sel,
           i_funct3, i_addr_lo, i_dmem_rdata, i_alu_result, i_pc_plus4, i_imm,
    input  o_rd_wen, o_rd_addr, o_rd_wdata, o_fwd_valid, o_retire, o_retire_inst,
           o_trap_misaligned, o_instret
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_inst, i_rd_addr, i_reg_wr_en, i_wb_sel,
           i_funct3, i_addr_lo, i_dmem_rdata, i_alu_result, i_pc_plus4, i_imm,
    output o_rd_wen, o_rd_addr, o_rd_wdata, o_fwd_valid, o_retire, o_retire_inst,
           o_trap_misaligned, o_instret
  );
endinterface

// File: rtl/load_align.sv
// Load data alignment: byte-shift the raw word and size/sign-extend per funct3.
module load_align
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;

  // Shift the addressed byte lane down to bit 0, then extend by load type.
  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    data       = '0;
    misaligned = is_misaligned(funct3, addr_lo);
    case (funct3)
      F3_LB:   data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LW:   data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: load align + WB mux into the MEM/WB register, which
// drives the register-file write port, forwarding and retirement/minstret.
module wb_stage
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic      i_clk,
  input  logic      i_rst,
  wb_stage_if.slave bus
);

  logic [XLEN-1:0]      load_data;
  logic                 load_mis;
  logic                 mem_trap;
  logic [XLEN-1:0]      wb_data;
  logic                 retire;

  logic                 valid_q,   valid_d;
  logic                 wr_en_q,   wr_en_d;
  logic [4:0]           rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]      wdata_q,   wdata_d;
  logic [31:0]          inst_q,    inst_d;
  logic                 trap_q,    trap_d;
  logic                 retired_q, retired_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata      (bus.i_dmem_rdata),
    .addr_lo    (bus.i_addr_lo),
    .funct3     (bus.i_funct3),
    .data       (load_data),
    .misaligned (load_mis)
  );

  // Writeback source select; a misaligned load traps only when memory is the source.
  always_comb begin
    wb_data  = '0;
    mem_trap = 1'b0;
    case (wb_sel_e'(bus.i_wb_sel))
      WB_SEL_ALU: wb_data = bus.i_alu_result;
      WB_SEL_MEM: begin
        wb_data  = load_data;
        mem_trap = load_mis;
      end
      WB_SEL_PC4: wb_data = bus.i_pc_plus4;
      WB_SEL_IMM: wb_data = bus.i_imm;
      default:    wb_data = '0;
    endcase
  end

  // Retire once per entry: the retired flag latches during a stall so a held
  // entry keeps writing rd but never pulses retire twice.
  assign retire = valid_q & ~trap_q & ~retired_q;

  // Stage-register next state: flush beats stall beats capture.
  always_comb begin
    valid_d   = valid_q;
    wr_en_d   = wr_en_q;
    rd_addr_d = rd_addr_q;
    wdata_d   = wdata_q;
    inst_d    = inst_q;
    trap_d    = trap_q;
    retired_d = retired_q;
    instret_d = instret_q + INSTRET_W'(retire);
    if (bus.i_flush) begin
      valid_d   = 1'b0;
      wr_en_d   = 1'b0;
      trap_d    = 1'b0;
      retired_d = 1'b0;
    end else if (bus.i_stall) begin
      retired_d = retired_q | valid_q;
    end else begin
      valid_d   = bus.i_valid;
      rd_addr_d = bus.i_rd_addr;
      wdata_d   = wb_data;
      inst_d    = bus.i_inst;
      trap_d    = bus.i_valid & mem_trap;
      wr_en_d   = bus.i_reg_wr_en & ~mem_trap & (bus.i_rd_addr != 5'd0);
      retired_d = 1'b0;
    end
  end

  // MEM/WB pipeline register and retired-instruction counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      valid_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wdata_q   <= '0;
      inst_q    <= '0;
      trap_q    <= 1'b0;
      retired_q <= 1'b0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      wdata_q   <= wdata_d;
      inst_q    <= inst_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
      instret_q <= instret_d;
    end
  end

  assign bus.o_rd_wen          = valid_q & wr_en_q;
  assign bus.o_fwd_valid       = valid_q & wr_en_q;
  assign bus.o_rd_addr         = rd_addr_q;
  assign bus.o_rd_wdata        = wdata_q;
  assign bus.o_retire          = retire;
  assign bus.o_retire_inst     = inst_q;
  assign bus.o_trap_misaligned = trap_q;
  assign bus.o_instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver updates a behavioural model and
// queues the expected outputs; a monitor pops and compares after each edge.
module tb_wb_stage;

  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32), .INSTRET_W(IW)) bus ();

  wb_stage #(.XLEN(32), .INSTRET_W(IW)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  logic [31:0] la_rdata;
  logic [1:0]  la_lo;
  logic [2:0]  la_f3;
  logic [31:0] la_data;
  logic        la_mis;

  load_align #(.XLEN(32)) u_la (
    .rdata      (la_rdata),
    .addr_lo    (la_lo),
    .funct3     (la_f3),
    .data       (la_data),
    .misaligned (la_mis)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          wen;
    bit          retire;
    bit          trap;
    bit          known;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] inst;
    int unsigned instret;
  } exp_t;

  exp_t sbq[$];

  // Behavioural model of the entry held in the stage.
  bit          m_valid, m_wen, m_trap, m_retired, m_known;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_inst;
  int unsigned m_instret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] lo,
                                           input logic [2:0] f3, output bit mis);
    logic [31:0] w;
    logic [31:0] r;
    w   = rdata >> (int'(lo) * 8);
    r   = 32'd0;
    mis = (((f3 == 3'd1) || (f3 == 3'd5)) && (lo % 2 == 1)) || ((f3 == 3'd2) && (lo != 2'd0));
    case (f3)
      3'd0: begin r = w & 32'hFF;   if (r >= 32'd128)   r = r - 32'd256;   end
      3'd4: r = w & 32'hFF;
      3'd1: begin r = w & 32'hFFFF; if (r >= 32'd32768) r = r - 32'd65536; end
      3'd5: r = w & 32'hFFFF;
      3'd2: r = w;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic void model_reset();
    m_valid = 0; m_wen = 0; m_trap = 0; m_retired = 0; m_known = 1;
    m_rd = '0; m_data = '0; m_inst = '0; m_instret = 0;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.wen     = m_valid & m_wen;
    e.retire  = m_valid & !m_trap & !m_retired;
    e.trap    = m_trap;
    e.known   = m_known;
    e.rd      = m_rd;
    e.wdata   = m_data;
    e.inst    = m_inst;
    e.instret = m_instret;
    sbq.push_back(e);
  endfunction

  // One clock of stimulus, applied at a falling edge.
  task automatic cycle(input bit rst, input bit v, input bit stall, input bit flush,
                       input logic [31:0] inst, input logic [4:0] rd, input bit we,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lo,
                       input logic [31:0] rdata, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] imm);
    bit was_rst_high;
    bit retire_now;
    bit mis;
    logic [31:0] ld;
    was_rst_high      = (rst_n === 1'b1);
    bus.i_valid       = v;
    bus.i_stall       = stall;
    bus.i_flush       = flush;
    bus.i_inst        = inst;
    bus.i_rd_addr     = rd;
    bus.i_reg_wr_en   = we;
    bus.i_wb_sel      = sel;
    bus.i_funct3      = f3;
    bus.i_addr_lo     = lo;
    bus.i_dmem_rdata  = rdata;
    bus.i_alu_result  = alu;
    bus.i_pc_plus4    = pc4;
    bus.i_imm         = imm;
    rst_n             = rst;
    if (!rst) begin
      model_reset();
      push_exp();
      if (was_rst_high) begin
        #1;
        chk("async_rst_wen",     bus.o_rd_wen, 0);
        chk("async_rst_retire",  bus.o_retire, 0);
        chk("async_rst_wdata",   bus.o_rd_wdata, 0);
        chk("async_rst_instret", bus.o_instret, 0);
      end
    end else begin
      retire_now = m_valid & !m_trap & !m_retired;
      if (flush) begin
        m_valid = 0; m_wen = 0; m_trap = 0; m_retired = 0; m_known = 0;
      end else if (stall) begin
        if (m_valid) m_retired = 1;
      end else begin
        ld = ref_load(rdata, lo, f3, mis);
        if (sel != 2'd1) mis = 0;
        m_valid   = v;
        m_trap    = v & mis;
        m_wen     = we & !mis & (rd != 0);
        m_rd      = rd;
        m_inst    = inst;
        m_retired = 0;
        m_known   = 1;
        case (sel)
          2'd0: m_data = alu;
          2'd1: m_data = ld;
          2'd2: m_data = pc4;
          default: m_data = imm;
        endcase
      end
      if (retire_now) m_instret = (m_instret + 1) % (1 << IW);
      push_exp();
    end
    @(negedge clk);
  endtask

  task automatic rand_cycle(input bit allow_rst);
    logic [2:0] f3;
    int unsigned pick;
    pick = $urandom_range(0, 7);
    case (pick)
      0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; 4: f3 = 3'd5;
      default: f3 = 3'($urandom);
    endcase
    cycle(!(allow_rst && ($urandom_range(0, 99) == 0)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          $urandom, 5'($urandom), $urandom_range(0, 4) != 0, 2'($urandom), f3,
          2'($urandom), $urandom, $urandom, $urandom, $urandom);
  endtask

  // Monitor: compare the queued expectation one time step after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rd_wen",    bus.o_rd_wen, e.wen);
        chk("fwd_valid", bus.o_fwd_valid, e.wen);
        chk("retire",    bus.o_retire, e.retire);
        chk("trap",      bus.o_trap_misaligned, e.trap);
        chk("instret",   bus.o_instret, e.instret);
        if (e.known) begin
          chk("rd_addr",     bus.o_rd_addr, e.rd);
          chk("rd_wdata",    bus.o_rd_wdata, e.wdata);
          chk("retire_inst", bus.o_retire_inst, e.inst);
        end
      end
    end
  end

  initial begin
    bit mis;
    logic [31:0] ld;
    int unsigned waited;

    // Standalone load_align vectors.
    for (int i = 0; i < 300; i++) begin
      la_rdata = $urandom;
      la_lo    = 2'($urandom);
      la_f3    = 3'($urandom);
      #1;
      ld = ref_load(la_rdata, la_lo, la_f3, mis);
      chk("la_data", la_data, ld);
      chk("la_mis",  la_mis, mis);
    end

    bus.i_valid = 0; bus.i_stall = 0; bus.i_flush = 0; bus.i_inst = '0;
    bus.i_rd_addr = '0; bus.i_reg_wr_en = 0; bus.i_wb_sel = '0; bus.i_funct3 = '0;
    bus.i_addr_lo = '0; bus.i_dmem_rdata = '0; bus.i_alu_result = '0;
    bus.i_pc_plus4 = '0; bus.i_imm = '0;
    rst_n = 0;
    model_reset();
    #1;
    chk("reset_wen",     bus.o_rd_wen, 0);
    chk("reset_retire",  bus.o_retire, 0);
    chk("reset_instret", bus.o_instret, 0);
    chk("reset_inst",    bus.o_retire_inst, 0);
    @(negedge clk);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed: LB sign-extend, LHU, misaligned LH, rd=x0, link value.
    cycle(1, 1, 0, 0, 32'h0031_8283, 5'd5, 1, 2'd1, 3'd0, 2'd3, 32'h80FF_7F01, 32'h1003, 0, 0);
    cycle(1, 1, 0, 0, 32'h0023_D303, 5'd6, 1, 2'd1, 3'd5, 2'd2, 32'h8001_1234, 32'h1002, 0, 0);
    cycle(1, 1, 0, 0, 32'h0011_9383, 5'd7, 1, 2'd1, 3'd1, 2'd1, 32'h8001_1234, 32'h1001, 0, 0);
    cycle(1, 1, 0, 0, 32'h0000_0033, 5'd0, 1, 2'd0, 3'd0, 2'd3, 0, 32'hDEAD_BEEF, 0, 0);
    cycle(1, 1, 0, 0, 32'h0040_00EF, 5'd1, 1, 2'd2, 3'd0, 2'd0, 0, 0, 32'h104, 0);

    // Directed: ADD held for three stall cycles.
    cycle(1, 1, 0, 0, 32'h0020_81B3, 5'd3, 1, 2'd0, 3'd0, 2'd0, 0, 32'h55, 0, 0);
    for (int i = 0; i < 3; i++)
      cycle(1, 1, 1, 0, $urandom, 5'($urandom), 1, 2'($urandom), 3'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, $urandom);

    // Directed: flush and stall together with a valid input.
    cycle(1, 1, 1, 1, 32'h1234_5678, 5'd9, 1, 2'd3, 3'd0, 2'd0, 0, 0, 0, 32'hABCD_0000);
    cycle(1, 1, 0, 0, 32'h0000_0037, 5'd10, 1, 2'd3, 3'd0, 2'd0, 0, 0, 0, 32'hABCD_0000);

    // Directed: reset asserted while an entry is held under stall.
    cycle(1, 1, 0, 0, 32'h0000_0013, 5'd11, 1, 2'd0, 3'd0, 2'd0, 0, 32'h77, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back retires to carry o_instret through its wrap.
    for (int i = 0; i < 70; i++)
      cycle(1, 1, 0, 0, $urandom, 5'($urandom), 1, 2'd0, 3'd0, 2'd0, 0, $urandom, 0, 0);

    for (int i = 0; i < 800; i++) rand_cycle(1);

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    waited = 0;
    while (sbq.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sbq.size() > 0) chk("scoreboard_drain", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
